// File: rtl/i2c_pkg.sv
// Shared types for the I2C request arbiter.
// Holds the arbiter FSM state encoding and the default abort timeout.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_DONE = 3'd3,
    COMPLETE  = 3'd4,
    DRAIN     = 3'd5
  } state_t;

  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int CNT_MIN_W       = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req_i bit searching from last_owner_i+1.
// Ports: req_i, last_owner_i in; onehot_o, idx_o, valid_o out.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    last_owner_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  logic [IW-1:0] p;

  // Walk from farthest to nearest so the nearest candidate wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    p        = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      p = IW'((int'(last_owner_i) + k) % N_REQ);
      if (req_i[p]) begin
        onehot_o    = '0;
        onehot_o[p] = 1'b1;
        idx_o       = p;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master among N_REQ requesters, round-robin, with timeout.
// Ports: req/req_wr/req_addr/req_wdata in, gnt/req_done/req_err/rdata out, m_* to master.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_wr,
  input  logic [N_REQ*7-1:0] req_addr,
  input  logic [N_REQ*8-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   req_done,
  output logic               req_err,
  output logic [7:0]         rdata,
  output logic               m_en,
  output logic               m_wr_rdn,
  output logic [6:0]         m_addr,
  output logic [7:0]         m_wdata,
  input  logic [7:0]         m_rdata,
  input  logic               m_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = (TW > CNT_MIN_W) ? TW : CNT_MIN_W;

  state_t           state_q, state_d;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    owner_q;
  logic [N_REQ-1:0] gnt_q;
  logic             wr_q;
  logic [6:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata_q;
  logic             err_q;
  logic [CW-1:0]    cnt_q;
  logic             sync1_q, sync2_q, prev_q;

  logic [N_REQ-1:0] arb_onehot;
  logic [IW-1:0]    arb_idx;
  logic             arb_valid;
  logic             done_rise;
  logic             timeout;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .req_i        (req),
    .last_owner_i (last_q),
    .onehot_o     (arb_onehot),
    .idx_o        (arb_idx),
    .valid_o      (arb_valid)
  );

  assign done_rise = sync2_q & ~prev_q;
  assign timeout   = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (|req) state_d = ARB;
      ARB:       state_d = arb_valid ? LAUNCH : IDLE;
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (done_rise || timeout) state_d = COMPLETE;
      COMPLETE:  state_d = DRAIN;
      DRAIN:     if (!sync2_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= IDLE;
      last_q  <= IW'(N_REQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= m_done;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (state_q == ARB && arb_valid) begin
        gnt_q   <= arb_onehot;
        owner_q <= arb_idx;
        wr_q    <= req_wr[arb_idx];
        addr_q  <= req_addr[int'(arb_idx)*7 +: 7];
        wdata_q <= req_wdata[int'(arb_idx)*8 +: 8];
        err_q   <= 1'b0;
      end
      if (state_q == LAUNCH) cnt_q <= '0;
      if (state_q == WAIT_DONE) begin
        cnt_q <= cnt_q + CW'(1);
        // A real done wins over a coincident timeout.
        if (done_rise) rdata_q <= m_rdata;
        else if (timeout) err_q <= 1'b1;
      end
      if (state_q == COMPLETE) begin
        last_q <= owner_q;
        gnt_q  <= '0;
      end
    end
  end

  assign gnt      = gnt_q;
  assign req_done = (state_q == COMPLETE) ? gnt_q : '0;
  assign req_err  = (state_q == COMPLETE) & err_q;
  assign rdata    = rdata_q;
  assign m_en     = (state_q == WAIT_DONE);
  assign m_wr_rdn = wr_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: vector table plus corner sequences.
// Second instance with TIMEOUT_CYC=64 exercises the abort path.
module tb_i2c_req_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req, req_wr;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  m_rdata;
  logic        m_done;
  logic        m_done_to;

  logic [3:0]  gnt, req_done;
  logic        req_err, m_en, m_wr_rdn;
  logic [7:0]  rdata, m_wdata;
  logic [6:0]  m_addr;

  logic [3:0]  to_gnt, to_done;
  logic        to_err, to_en, to_wr;
  logic [7:0]  to_rdata, to_wdata;
  logic [6:0]  to_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.N_REQ(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .req_done(req_done), .req_err(req_err), .rdata(rdata),
    .m_en(m_en), .m_wr_rdn(m_wr_rdn), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done)
  );

  i2c_req_arbiter #(.N_REQ(4), .TIMEOUT_CYC(64)) u_to (
    .clk(clk), .reset_n(reset_n), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(to_gnt),
    .req_done(to_done), .req_err(to_err), .rdata(to_rdata),
    .m_en(to_en), .m_wr_rdn(to_wr), .m_addr(to_addr),
    .m_wdata(to_wdata), .m_rdata(m_rdata), .m_done(m_done_to)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    req     = '0;
    m_done  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
  endtask

  // One transfer: master model raises m_done once m_en has been high
  // for busy cycles; the 2-flop sync adds two more m_en cycles.
  task automatic xfer(input logic [3:0] r, input logic [3:0] w,
                      input logic [7:0] rd, input int busy,
                      input logic drop,
                      output logic [3:0] g, output logic [6:0] a,
                      output logic [7:0] d, output logic wr,
                      output logic [7:0] rdat, output logic [3:0] dv,
                      output logic err, output int en_cyc,
                      output int extra, output logic stable);
    int n;
    req     = r;
    req_wr  = w;
    m_rdata = rd;
    n = 0;
    while (gnt == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_seen", {31'd0, |gnt}, 32'd1);
    g  = gnt;
    a  = m_addr;
    d  = m_wdata;
    wr = m_wr_rdn;
    if (drop) req = '0;
    en_cyc = 0;
    stable = 1'b1;
    n = 0;
    while (req_done == 0 && n < 5000) begin
      if (m_en) en_cyc++;
      if (en_cyc == busy) m_done = 1'b1;
      @(negedge clk);
      n++;
      if (m_addr !== a || m_wdata !== d || m_wr_rdn !== wr)
        stable = 1'b0;
    end
    chk("done_seen", {31'd0, |req_done}, 32'd1);
    dv     = req_done;
    rdat   = rdata;
    err    = req_err;
    m_done = 1'b0;
    extra  = 0;
    repeat (3) begin
      @(negedge clk);
      if (req_done != 0) extra++;
    end
  endtask

  typedef struct {
    logic [3:0] r;
    logic [3:0] w;
    logic [7:0] rd;
    logic [3:0] eg;
    logic [6:0] ea;
    logic [7:0] ed;
    logic       ewr;
  } vec_t;

  vec_t vt[6];

  logic [3:0] g, dv;
  logic [6:0] a;
  logic [7:0] d, rdat;
  logic       wr, err, stable;
  int         en_cyc, extra, n, cnt;
  logic [3:0] order [5];

  initial begin
    req_addr  = {7'h53, 7'h52, 7'h51, 7'h50};
    req_wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
    req_wr    = '0;
    m_rdata   = '0;
    m_done_to = 1'b0;

    // Rotation after reset starts at requester 0 (last owner = 3).
    vt[0] = '{4'b0001, 4'b0001, 8'h11, 4'b0001, 7'h50, 8'hA5, 1'b1};
    vt[1] = '{4'b0101, 4'b0000, 8'h22, 4'b0100, 7'h52, 8'hC2, 1'b0};
    vt[2] = '{4'b0101, 4'b0100, 8'h33, 4'b0001, 7'h50, 8'hA5, 1'b0};
    vt[3] = '{4'b1010, 4'b1010, 8'h44, 4'b0010, 7'h51, 8'hB1, 1'b1};
    vt[4] = '{4'b1001, 4'b0001, 8'h55, 4'b1000, 7'h53, 8'hD3, 1'b0};
    vt[5] = '{4'b1111, 4'b1000, 8'h66, 4'b0001, 7'h50, 8'hA5, 1'b0};

    do_reset();
    reset_n = 1'b1;
    #1;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_men", {31'd0, m_en}, 32'd0);
    chk("rst_addr", {25'd0, m_addr}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_wr", {31'd0, m_wr_rdn}, 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      xfer(vt[i].r, vt[i].w, vt[i].rd, 5, 1'b0,
           g, a, d, wr, rdat, dv, err, en_cyc, extra, stable);
      req = '0;
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {28'd0, g}, {28'd0, vt[i].eg});
      chk($sformatf("v%0d_addr", i), {25'd0, a}, {25'd0, vt[i].ea});
      chk($sformatf("v%0d_wdata", i), {24'd0, d}, {24'd0, vt[i].ed});
      chk($sformatf("v%0d_wr", i), {31'd0, wr}, {31'd0, vt[i].ewr});
      chk($sformatf("v%0d_done", i), {28'd0, dv}, {28'd0, vt[i].eg});
      chk($sformatf("v%0d_rdata", i), {24'd0, rdat}, {24'd0, vt[i].rd});
      chk($sformatf("v%0d_err", i), {31'd0, err}, 32'd0);
      chk($sformatf("v%0d_pulse", i), extra, 0);
      chk($sformatf("v%0d_stable", i), {31'd0, stable}, 32'd1);
    end

    // Single write, long master busy, req dropped after grant.
    do_reset();
    req    = 4'b0001;
    req_wr = 4'b0001;
    @(negedge clk);
    chk("lat_arb", {28'd0, gnt}, 32'd0);
    @(negedge clk);
    chk("lat_gnt", {28'd0, gnt}, 32'd1);
    xfer(4'b0001, 4'b0001, 8'h00, 298, 1'b1,
         g, a, d, wr, rdat, dv, err, en_cyc, extra, stable);
    chk("w_en_cyc", en_cyc, 300);
    chk("w_done", {28'd0, dv}, 32'd1);
    chk("w_err", {31'd0, err}, 32'd0);
    chk("w_pulse", extra, 0);
    chk("w_addr", {25'd0, a}, 32'h50);
    chk("w_wdata", {24'd0, d}, 32'hA5);

    // All requesting continuously: strict rotation.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xfer(4'b1111, 4'b0000, 8'h00, 4, 1'b0,
           g, a, d, wr, rdat, dv, err, en_cyc, extra, stable);
      order[i] = g;
    end
    req = '0;
    repeat (6) @(negedge clk);
    chk("rr_0", {28'd0, order[0]}, 32'b0001);
    chk("rr_1", {28'd0, order[1]}, 32'b0010);
    chk("rr_2", {28'd0, order[2]}, 32'b0100);
    chk("rr_3", {28'd0, order[3]}, 32'b1000);
    chk("rr_4", {28'd0, order[4]}, 32'b0001);

    // Read from requester 2.
    do_reset();
    xfer(4'b0100, 4'b0000, 8'h3C, 10, 1'b0,
         g, a, d, wr, rdat, dv, err, en_cyc, extra, stable);
    req = '0;
    repeat (6) @(negedge clk);
    chk("rd_done", {28'd0, dv}, 32'b0100);
    chk("rd_data", {24'd0, rdat}, 32'h3C);
    chk("rd_wr", {31'd0, wr}, 32'd0);

    // Reset in WAIT_DONE: last owner is 2 here, so only a reset
    // of the rotation pointer sends the next grant to requester 0.
    req    = 4'b0010;
    req_wr = 4'b0010;
    n = 0;
    while (!m_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mr_men", {31'd0, m_en}, 32'd1);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mr_gnt", {28'd0, gnt}, 32'd0);
    chk("mr_en", {31'd0, m_en}, 32'd0);
    chk("mr_addr", {25'd0, m_addr}, 32'd0);
    chk("mr_wdata", {24'd0, m_wdata}, 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (req_done != 0) cnt++;
    end
    reset_n = 1'b0;
    req     = 4'b1111;
    n = 0;
    while (gnt == 0 && n < 50) begin
      @(negedge clk);
      if (req_done != 0) cnt++;
      n++;
    end
    chk("mr_nodone", cnt, 0);
    chk("mr_next", {28'd0, gnt}, 32'b0001);

    // Timeout instance: master never answers.
    do_reset();
    m_rdata = 8'hEE;
    req     = 4'b0001;
    cnt = 0;
    n   = 0;
    while (to_done == 0 && n < 500) begin
      @(negedge clk);
      if (to_en) cnt++;
      n++;
    end
    chk("to_en_cyc", cnt, 64);
    chk("to_done", {28'd0, to_done}, 32'b0001);
    chk("to_err", {31'd0, to_err}, 32'd1);
    chk("to_rdata", {24'd0, to_rdata}, 32'd0);
    @(negedge clk);
    chk("to_err_pulse", {31'd0, to_err}, 32'd0);

    // m_done stuck high past COMPLETE blocks the next grant.
    do_reset();
    req = 4'b0001;
    n = 0;
    while (!m_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    req    = '0;
    m_done = 1'b1;
    n = 0;
    while (req_done == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("st_done", {28'd0, req_done}, 32'b0001);
    req = 4'b0010;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (gnt != 0) cnt++;
    end
    chk("st_hold", cnt, 0);
    m_done = 1'b0;
    n = 0;
    while (gnt == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("st_next", {28'd0, gnt}, 32'b0010);

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
